exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 157 +++++++++++++++
 tb/tb_exc_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer at the M stage: entry/return redirect, interrupt pending and ack, entry counter.
// Optional EXC_CTRL_IRQ_EDGE_EN: rising-edge latched interrupts cleared by ack (default: level-following).
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_irq,
    input  logic [5:0]  sr_im,
    input  logic        m_valid,
    input  logic [4:0]  exc_code_m,
    input  logic        eret_m,
    input  logic        cp0_req,
    input  logic [31:0] epc,
    output logic [5:0]  hwint,
    output logic [5:0]  irq_ack,
    output logic        flush,
    output logic        npc_sel,
    output logic [31:0] npc,
    output logic        exl_clr,
    output logic [15:0] exc_count
);

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  pending_r;
    logic [2:0]  svc_r;
    logic        svc_vld_r;
    logic [15:0] exc_count_r;

    logic        accept_exc_s;
    logic        accept_eret_s;
    logic [5:0]  masked_s;
    logic [2:0]  svc_sel_s;
    logic [5:0]  ack_s;
    logic [5:0]  pend_nxt_s;

    // Bit 0 has the highest priority.
    function automatic logic [2:0] lowest_bit(input logic [5:0] v);
        casez (v)
            6'b?????1: lowest_bit = 3'd0;
            6'b????10: lowest_bit = 3'd1;
            6'b???100: lowest_bit = 3'd2;
            6'b??1000: lowest_bit = 3'd3;
            6'b?10000: lowest_bit = 3'd4;
            6'b100000: lowest_bit = 3'd5;
            default:   lowest_bit = 3'd0;
        endcase
    endfunction

    // Acceptance decode, interrupt selection and acknowledge vector.
    always_comb begin
        accept_exc_s  = !reset && (state_r == RUN) && m_valid && cp0_req;
        accept_eret_s = !reset && (state_r == RUN) && m_valid && eret_m && !cp0_req;
        masked_s      = pending_r & sr_im;
        svc_sel_s     = lowest_bit(masked_s);
        if ((state_r == ENTER) && svc_vld_r) begin
            ack_s = 6'b000001 << svc_r;
        end else begin
            ack_s = 6'b000000;
        end
    end

`ifdef EXC_CTRL_IRQ_EDGE_EN
    logic [5:0] hw_prev_r;

    // Previous interrupt levels for edge detection; tracks the lines even in reset so no false edge follows it.
    always_ff @(posedge clk) begin
        hw_prev_r <= hw_irq;
    end

    // Next pending: a new rising edge wins over the acknowledge clear.
    always_comb begin
        pend_nxt_s = (pending_r & ~ack_s) | (hw_irq & ~hw_prev_r);
    end
`else
    // Next pending: simply follows the device lines.
    always_comb begin
        pend_nxt_s = hw_irq;
    end
`endif

    // Same-cycle redirect outputs (Mealy) and gated acknowledge.
    always_comb begin
        flush   = 1'b0;
        npc_sel = 1'b0;
        exl_clr = 1'b0;
        npc     = EXC_VECTOR;
        if (accept_exc_s) begin
            flush   = 1'b1;
            npc_sel = 1'b1;
        end else if (accept_eret_s) begin
            flush   = 1'b1;
            npc_sel = 1'b1;
            exl_clr = 1'b1;
            npc     = epc;
        end else begin
            flush   = 1'b0;
            npc_sel = 1'b0;
        end
        if (reset) begin
            irq_ack = 6'b000000;
        end else begin
            irq_ack = ack_s;
        end
    end

    // Control FSM, pending register, serviced-interrupt latch and entry counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            pending_r   <= 6'b000000;
            svc_r       <= 3'd0;
            svc_vld_r   <= 1'b0;
            exc_count_r <= 16'h0000;
        end else begin
            pending_r <= pend_nxt_s;
            case (state_r)
                RUN: begin
                    if (accept_exc_s) begin
                        state_r <= ENTER;
                        if (exc_code_m == 5'd0) begin
                            svc_r     <= svc_sel_s;
                            svc_vld_r <= |masked_s;
                        end else begin
                            svc_vld_r <= 1'b0;
                        end
                    end else if (accept_eret_s) begin
                        state_r <= RETURN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                ENTER: begin
                    state_r   <= RUN;
                    svc_vld_r <= 1'b0;
                end
                RETURN:  state_r <= RUN;
                default: state_r <= RUN;
            endcase
            if (accept_exc_s && (exc_count_r != 16'hFFFF)) begin
                exc_count_r <= exc_count_r + 16'd1;
            end else begin
                exc_count_r <= exc_count_r;
            end
        end
    end

    assign hwint     = pending_r;
    assign exc_count = exc_count_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a cycle model pushes expected outputs, popped and compared before the clock edge.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  hw_irq = 6'b000000;
    logic [5:0]  sr_im = 6'b000000;
    logic        m_valid = 1'b0;
    logic [4:0]  exc_code_m = 5'd0;
    logic        eret_m = 1'b0;
    logic        cp0_req = 1'b0;
    logic [31:0] epc = 32'h0000_0000;
    logic [5:0]  hwint;
    logic [5:0]  irq_ack;
    logic        flush;
    logic        npc_sel;
    logic [31:0] npc;
    logic        exl_clr;
    logic [15:0] exc_count;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .hw_irq(hw_irq), .sr_im(sr_im), .m_valid(m_valid),
        .exc_code_m(exc_code_m), .eret_m(eret_m), .cp0_req(cp0_req), .epc(epc),
        .hwint(hwint), .irq_ack(irq_ack), .flush(flush), .npc_sel(npc_sel), .npc(npc),
        .exl_clr(exl_clr), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        npc_sel;
        logic [31:0] npc;
        logic        exl_clr;
        logic [5:0]  irq_ack;
        logic [5:0]  hwint;
        logic [15:0] exc_count;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: 0 RUN, 1 ENTER, 2 RETURN.
    int          m_st = 0;
    logic [5:0]  m_pend = 6'b000000;
    logic [5:0]  m_prev = 6'b000000;
    int          m_svc = 0;
    bit          m_svc_v = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] hw, input logic [5:0] im, input logic mv,
                        input logic [4:0] code, input logic er, input logic cp, input logic [31:0] pc);
        exp_t       e;
        exp_t       o;
        bit         ae;
        bit         ar;
        logic [5:0] ms;
        @(negedge clk);
        reset = rst; hw_irq = hw; sr_im = im; m_valid = mv;
        exc_code_m = code; eret_m = er; cp0_req = cp; epc = pc;
        ae = !rst && (m_st == 0) && mv && cp;
        ar = !rst && (m_st == 0) && mv && er && !cp;
        e.flush     = ae || ar;
        e.npc_sel   = ae || ar;
        e.exl_clr   = ar;
        e.npc       = ar ? pc : 32'h0000_4180;
        e.irq_ack   = (!rst && (m_st == 1) && m_svc_v) ? (6'b000001 << m_svc) : 6'b000000;
        e.hwint     = m_pend;
        e.exc_count = m_cnt;
        sb_q.push_back(e);
        #3;
        o = sb_q.pop_front();
        chk_val("flush", {31'd0, flush}, {31'd0, o.flush});
        chk_val("npc_sel", {31'd0, npc_sel}, {31'd0, o.npc_sel});
        chk_val("npc", npc, o.npc);
        chk_val("exl_clr", {31'd0, exl_clr}, {31'd0, o.exl_clr});
        chk_val("irq_ack", {26'd0, irq_ack}, {26'd0, o.irq_ack});
        chk_val("hwint", {26'd0, hwint}, {26'd0, o.hwint});
        chk_val("exc_count", {16'd0, exc_count}, {16'd0, o.exc_count});
        // Advance the model to the state after the coming clock edge.
        ms = m_pend & im;
        if (rst) begin
            m_st = 0; m_pend = 6'b000000; m_svc = 0; m_svc_v = 1'b0; m_cnt = 16'h0000;
        end else begin
`ifdef EXC_CTRL_IRQ_EDGE_EN
            m_pend = (m_pend & ~e.irq_ack) | (hw & ~m_prev);
`else
            m_pend = hw;
`endif
            if (ae) begin
                if (code == 5'd0) begin
                    m_svc_v = (ms != 6'b000000);
                    for (int i = 5; i >= 0; i--) if (ms[i]) m_svc = i;
                end else begin
                    m_svc_v = 1'b0;
                end
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            m_st = ae ? 1 : (ar ? 2 : 0);
        end
        m_prev = hw;
    endtask

    task automatic idle(input logic [5:0] hw, input logic [5:0] im);
        step(1'b0, hw, im, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000);
    endtask

    initial begin
        // Reset then quiet period.
        step(1'b1, 6'b000000, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 6'b000000, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) idle(6'b000000, 6'b000000);

        // Synchronous exception entry.
        step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd4, 1'b0, 1'b1, 32'h0);
        idle(6'b000000, 6'b111111);
        idle(6'b000000, 6'b111111);

        // Interrupt entry with two lines pending; bit 1 is serviced.
        idle(6'b000110, 6'b111111);
        idle(6'b000110, 6'b111111);
        step(1'b0, 6'b000110, 6'b111111, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0);
        idle(6'b000110, 6'b111111);
        idle(6'b000110, 6'b111111);
        idle(6'b000110, 6'b111111);
        idle(6'b000000, 6'b111111);
        idle(6'b000000, 6'b111111);

        // ERET, then held ERET during RETURN.
        step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0000_3010);
        step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0000_3010);
        idle(6'b000000, 6'b111111);

        // Exception beats ERET; request ignored in ENTER; bubble ignored.
        step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_3010);
        step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd3, 1'b0, 1'b1, 32'h0);
        step(1'b0, 6'b000000, 6'b111111, 1'b0, 5'd3, 1'b0, 1'b1, 32'h0);
        idle(6'b000000, 6'b111111);

        // Counter saturation, preloaded near the top instead of 65536 real entries.
        force dut.exc_count_r = 16'hFFFC;
        m_cnt = 16'hFFFC;
        #1;
        release dut.exc_count_r;
        idle(6'b000000, 6'b111111);
        for (int i = 0; i < 10; i++) step(1'b0, 6'b000000, 6'b111111, 1'b1, 5'd4, 1'b0, 1'b1, 32'h0);
        idle(6'b000000, 6'b111111);

        // Reset asserted in ENTER of an interrupt entry.
        idle(6'b000001, 6'b111111);
        idle(6'b000001, 6'b111111);
        step(1'b0, 6'b000001, 6'b111111, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 6'b000001, 6'b111111, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle(6'b000001, 6'b111111);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  rhw;
            logic [31:0] rpc;
            rhw = 6'($urandom_range(0, 63));
            rpc = $urandom() & 32'hFFFF_FFFC;
            step(($urandom_range(0, 29) == 0), rhw, 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(1, 31)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), rpc);
        end

        step(1'b1, 6'b000000, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle(6'b000000, 6'b000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
